// File: rtl/jacobi_pkg.sv
// Shared types and sizing for the Jacobi solver front end.
// The loader and its frame buffer both import this package.
package jacobi_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_IT = 3'd1,
    HDR_TH = 3'd2,
    FILL   = 3'd3,
    BURST  = 3'd4,
    WAIT   = 3'd5,
    ERR    = 3'd6
  } state_e;

  localparam int HDR_WORDS = 3;
  localparam int MAX_N     = 8;
  localparam int BUF_DEPTH = HDR_WORDS + MAX_N * MAX_N + MAX_N;

  // Payload length in words: N*N matrix entries plus N b-vector entries.
  function automatic logic [15:0] payload_len(input logic [7:0] n);
    return 16'(n) * 16'(n) + 16'(n);
  endfunction

endpackage

// File: rtl/frame_buf.sv
// Register-array frame store: one synchronous write port, one asynchronous read port.
// Addresses beyond the depth are ignored on write and read back as zero.
module frame_buf
  import jacobi_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         we_i,
  input  logic [7:0]   waddr_i,
  input  logic [W-1:0] wdata_i,
  input  logic [7:0]   raddr_i,
  output logic [W-1:0] rdata_o
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [7:0] DEPTH_L = 8'(DEPTH);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i && (waddr_i < DEPTH_L)) begin
      mem_q[waddr_i[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = (raddr_i < DEPTH_L) ? mem_q[raddr_i[AW-1:0]] : '0;

endmodule

// File: rtl/jacobi_loader.sv
// Store-and-forward framer: buffers one validated host frame, then replays it
// to the solver as a gap-free burst headed by a one-cycle sol_go.
module jacobi_loader
  import jacobi_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] host_data,
  input  logic         host_valid,
  output logic         host_ready,
  output logic [W-1:0] sol_din,
  output logic         sol_valid,
  output logic         sol_go,
  input  logic         sol_done,
  output logic         busy,
  output logic         err
);

  state_e       state_q;
  logic [15:0]  len_q;
  logic [7:0]   widx_q;
  logic [7:0]   ridx_q;
  logic [W-1:0] sol_din_q;
  logic         sol_valid_q;
  logic         sol_go_q;

  logic         accept;
  logic         hdr_ok;
  logic         last_fill;
  logic         last_burst;
  logic [W-1:0] rd_word;

  assign host_ready = (state_q == IDLE) || (state_q == HDR_IT) ||
                      (state_q == HDR_TH) || (state_q == FILL);
  assign busy       = (state_q == FILL) || (state_q == BURST) || (state_q == WAIT);
  assign err        = (state_q == ERR);
  assign sol_din    = sol_din_q;
  assign sol_valid  = sol_valid_q;
  assign sol_go     = sol_go_q;

  assign accept     = host_valid & host_ready;
  assign hdr_ok     = (host_data[W-1:8] == '0) && (host_data[7:0] != 8'd0) &&
                      (host_data[7:0] <= 8'(MAX_N));
  // The write index counts every accepted word, header included, so the last
  // payload word lands at index L+2 and the burst ends after index L+2 is read.
  assign last_fill  = ({8'd0, widx_q} == len_q + 16'(HDR_WORDS - 1));
  assign last_burst = ({8'd0, ridx_q} == len_q + 16'(HDR_WORDS));

  frame_buf #(.DEPTH(BUF_DEPTH), .W(W)) u_buf (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (widx_q),
    .wdata_i (host_data),
    .raddr_i (ridx_q),
    .rdata_o (rd_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= 16'd0;
      widx_q      <= 8'd0;
      ridx_q      <= 8'd0;
      sol_din_q   <= '0;
      sol_valid_q <= 1'b0;
      sol_go_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (hdr_ok) begin
              len_q   <= payload_len(host_data[7:0]);
              widx_q  <= widx_q + 8'd1;
              state_q <= HDR_IT;
            end else begin
              state_q <= ERR;
            end
          end
        end
        HDR_IT: begin
          if (accept) begin
            widx_q  <= widx_q + 8'd1;
            state_q <= HDR_TH;
          end
        end
        HDR_TH: begin
          if (accept) begin
            widx_q  <= widx_q + 8'd1;
            state_q <= FILL;
          end
        end
        FILL: begin
          if (accept) begin
            widx_q <= widx_q + 8'd1;
            // Word 0 (N) goes out on the same edge that takes the last payload word.
            if (last_fill) begin
              sol_din_q   <= rd_word;
              sol_valid_q <= 1'b1;
              sol_go_q    <= 1'b1;
              ridx_q      <= 8'd1;
              state_q     <= BURST;
            end
          end
        end
        BURST: begin
          sol_go_q <= 1'b0;
          if (last_burst) begin
            sol_din_q   <= '0;
            sol_valid_q <= 1'b0;
            state_q     <= WAIT;
          end else begin
            sol_din_q <= rd_word;
            ridx_q    <= ridx_q + 8'd1;
          end
        end
        WAIT: begin
          if (sol_done) begin
            widx_q  <= 8'd0;
            ridx_q  <= 8'd0;
            state_q <= IDLE;
          end
        end
        ERR: begin
          state_q <= ERR;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jacobi_loader.sv
// Self-checking bench for jacobi_loader: directed scenarios plus randomized frames
// compared against a frame-level model (the burst must equal the accepted frame).
module tb_jacobi_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] host_data;
  logic        host_valid;
  logic        host_ready;
  logic [31:0] sol_din;
  logic        sol_valid;
  logic        sol_go;
  logic        sol_done;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  jacobi_loader #(.W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .host_data  (host_data),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .sol_din    (sol_din),
    .sol_valid  (sol_valid),
    .sol_go     (sol_go),
    .sol_done   (sol_done),
    .busy       (busy),
    .err        (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0, acc_cyc = -1, go_cnt = 0, go_cyc = -1, first_v = -1, last_v = -1;
  logic [31:0] burst_q[$];
  bit tog = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Passive monitor: logs acceptances, go pulses and burst words per cycle.
  always @(negedge clk) begin
    cyc++;
    if (host_valid && host_ready) acc_cyc = cyc;
    if (sol_go) begin
      go_cnt++;
      go_cyc = cyc;
    end
    if (sol_valid) begin
      if (burst_q.size() == 0) first_v = cyc;
      burst_q.push_back(sol_din);
      last_v = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    go_cnt = 0; go_cyc = -1; first_v = -1; last_v = -1; acc_cyc = -1;
    burst_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; host_valid = 1'b0; sol_done = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_mon();
  endtask

  function automatic bit hdr_bad(input logic [31:0] w);
    return (w > 32'd8) || (w == 32'd0);
  endfunction

  task automatic make_frame(input int n, output logic [31:0] f[$]);
    f = {};
    f.push_back(32'(n));
    f.push_back($urandom);
    f.push_back($urandom);
    for (int i = 0; i < n * n + n; i++) f.push_back($urandom);
  endtask

  // mode 0: no gaps, 1: valid toggles every cycle, 2: random gaps.
  task automatic send_words(input logic [31:0] w[$], input int mode);
    bit done;
    int guard;
    for (int i = 0; i < w.size(); i++) begin
      done = 1'b0;
      guard = 0;
      while (!done && guard < 100) begin
        case (mode)
          1:       host_valid = tog;
          2:       host_valid = ($urandom_range(0, 2) != 0);
          default: host_valid = 1'b1;
        endcase
        tog = !tog;
        host_data = w[i];
        @(negedge clk);
        done = host_valid && host_ready;
        @(posedge clk); #1;
        guard++;
      end
      if (!done) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    host_valid = 1'b0;
  endtask

  task automatic expect_burst(input logic [31:0] exp[$], input string tag);
    int guard;
    bit fin;
    guard = 0;
    fin = 1'b0;
    while (!fin && guard < 400) begin
      @(negedge clk); #1;
      guard++;
      if (burst_q.size() > 0 && !sol_valid) fin = 1'b1;
    end
    check({tag, "_timeout"}, 32'(fin), 32'd1);
    check({tag, "_len"}, burst_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check({tag, "_word"}, (i < burst_q.size()) ? burst_q[i] : 32'hDEAD_BEEF, exp[i]);
    check({tag, "_go_cnt"}, go_cnt, 32'd1);
    check({tag, "_latency"}, go_cyc - acc_cyc, 32'd1);
    check({tag, "_go_first"}, first_v, go_cyc);
    check({tag, "_contig"}, last_v - first_v + 1, burst_q.size());
    check({tag, "_din_idle"}, sol_din, 32'd0);
    check({tag, "_busy_wait"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic finish_frame(input string tag);
    int idle;
    idle = $urandom_range(0, 3);
    for (int i = 0; i < idle; i++) begin
      @(negedge clk);
      check({tag, "_busy_hold"}, 32'(busy), 32'd1);
      check({tag, "_rdy_hold"}, 32'(host_ready), 32'd0);
      @(posedge clk); #1;
    end
    sol_done = 1'b1;
    @(posedge clk); #1;
    sol_done = 1'b0;
    @(negedge clk);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check({tag, "_rdy_done"}, 32'(host_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic expect_err(input logic [31:0] w, input int mode, input string tag);
    logic [31:0] q[$];
    q = {};
    q.push_back(w);
    do_reset();
    send_words(q, mode);
    @(negedge clk);
    check({tag, "_err"}, 32'(err), 32'd1);
    check({tag, "_rdy"}, 32'(host_ready), 32'd0);
    repeat (5) @(negedge clk);
    #1;
    check({tag, "_no_go"}, go_cnt, 32'd0);
    check({tag, "_err_sticky"}, 32'(err), 32'd1);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check({tag, "_err_clr"}, 32'(err), 32'd0);
    check({tag, "_rdy_clr"}, 32'(host_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] f[$], p[$], f1[$], f2[$], f3[$], rest[$];
    logic [31:0] bad[3];
    logic [31:0] hw;
    int cnt, guard, n;

    reset = 1'b1; host_valid = 1'b0; host_data = 32'd0; sol_done = 1'b0;
    do_reset();
    @(negedge clk);
    check("rst_ready", 32'(host_ready), 32'd1);
    check("rst_din", sol_din, 32'd0);
    check("rst_valid", 32'(sol_valid), 32'd0);
    check("rst_go", 32'(sol_go), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;

    // Directed N=2 frame, no gaps, then with toggling valid.
    f = {32'd2, 32'd10, 32'd5, 32'd4, 32'd1, 32'd1, 32'd3, 32'd1, 32'd2};
    clear_mon();
    send_words(f, 0);
    expect_burst(f, "n2");
    finish_frame("n2");
    clear_mon();
    send_words(f, 1);
    expect_burst(f, "n2gap");
    finish_frame("n2gap");

    // Bad headers.
    bad[0] = 32'd0; bad[1] = 32'd9; bad[2] = 32'h0000_0102;
    for (int i = 0; i < 3; i++) expect_err(bad[i], 0, "badhdr");

    // Reset during FILL, then a clean N=1 frame.
    do_reset();
    p = {32'd2, 32'd1, 32'd2, 32'd9, 32'd9, 32'd9};
    send_words(p, 0);
    do_reset();
    f1 = {32'd1, 32'd7, 32'd3, 32'd4, 32'd8};
    send_words(f1, 0);
    expect_burst(f1, "n1");
    finish_frame("n1");

    // Second frame offered while waiting for sol_done.
    make_frame(3, f2);
    clear_mon();
    send_words(f2, 0);
    expect_burst(f2, "wait1");
    make_frame(2, f3);
    host_valid = 1'b1;
    host_data = f3[0];
    repeat (3) begin
      @(negedge clk);
      check("wait_rdy_low", 32'(host_ready), 32'd0);
      @(posedge clk); #1;
    end
    sol_done = 1'b1;
    @(negedge clk);
    check("wait_rdy_done_cyc", 32'(host_ready), 32'd0);
    @(posedge clk); #1;
    sol_done = 1'b0;
    clear_mon();
    @(negedge clk);
    check("wait_rdy_after", 32'(host_ready), 32'd1);
    check("wait_busy_after", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rest = f3[1:$];
    send_words(rest, 0);
    expect_burst(f3, "wait2");
    finish_frame("wait2");

    // Reset pulsed on burst word 4.
    make_frame(2, f);
    clear_mon();
    send_words(f, 0);
    cnt = 0;
    guard = 0;
    while (cnt < 4 && guard < 50) begin
      @(negedge clk); #1;
      if (sol_valid) cnt++;
      guard++;
    end
    check("midburst_reached", cnt, 32'd4);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midburst_valid", 32'(sol_valid), 32'd0);
    check("midburst_din", sol_din, 32'd0);
    check("midburst_busy", 32'(busy), 32'd0);
    check("midburst_rdy", 32'(host_ready), 32'd1);
    @(posedge clk); #1;

    // Randomized frames, occasionally with a bad header.
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 2))
          0:       hw = 32'd0;
          1:       hw = 32'($urandom_range(9, 255));
          default: hw = {$urandom_range(1, 255), 8'($urandom_range(1, 8))};
        endcase
        check("rand_model_bad", 32'(hdr_bad(hw)), 32'd1);
        expect_err(hw, 2, "rand_bad");
      end else begin
        n = $urandom_range(1, 8);
        make_frame(n, f);
        clear_mon();
        send_words(f, 2);
        expect_burst(f, "rand");
        finish_frame("rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
